// File: rtl/regfile_debug_master_pkg.sv
// Shared register-file word/index types plus the debug master's command and state encodings.
// REGFILE_DBG_VERIFY_EN adds the VERIFY (write readback) state.
package cpu_types_pkg;

   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      DBG_READ  = 2'b00,
      DBG_WRITE = 2'b01,
      DBG_DUMP  = 2'b10,
      DBG_CLEAR = 2'b11
   } dbg_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CLR,
      ST_RESP
`ifdef REGFILE_DBG_VERIFY_EN
      , ST_VERIFY
`endif
   } dbg_state_t;

endpackage

// File: rtl/regfile_debug_master_if.sv
// Register file access bundle: one write port, two combinational read ports.
// The tb modport is the write/select side used by the debug master.
interface register_file_if;
   import cpu_types_pkg::*;

   logic     wen;
   regbits_t wsel;
   regbits_t rsel1;
   regbits_t rsel2;
   word_t    wdat;
   word_t    rdat1;
   word_t    rdat2;

   modport rf (input wen, wsel, rsel1, rsel2, wdat, output rdat1, rdat2);
   modport tb (output wen, wsel, rsel1, rsel2, wdat, input rdat1, rdat2);

endinterface

// File: rtl/regfile_debug_master.sv
// Debug master: runs host READ/WRITE/DUMP/CLEAR commands against the register file, one access per cycle.
// Define REGFILE_DBG_VERIFY_EN to add a readback cycle after every WRITE with a sticky err flag.
module regfile_debug_master
   import cpu_types_pkg::*;
#(
   parameter int    NUM_REGS    = 32,
   parameter word_t CLEAR_VALUE = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  regbits_t    cmd_sel,
   input  word_t       cmd_wdat,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output regbits_t    rsp_sel,
   output word_t       rsp_dat,
   output logic        busy,
   output logic        err,
   register_file_if.tb rfif
);

   localparam regbits_t LAST_IDX  = regbits_t'(NUM_REGS - 1);
   localparam word_t    CLR_COUNT = word_t'(NUM_REGS - 1);

   dbg_state_t r_state;
   dbg_op_t    r_op;
   regbits_t   r_idx;
   word_t      r_wdat;
   logic       r_cmd_ready;
   logic       r_rsp_valid;
   logic       r_busy;
   regbits_t   r_rsp_sel;
   word_t      r_rsp_dat;
   logic       r_wen;
   regbits_t   r_wsel;
   regbits_t   r_rsel1;
   regbits_t   r_rsel2;
   word_t      r_rf_wdat;

   logic       w_cmd_fire;
   logic       w_rsp_fire;
   regbits_t   w_idx_next;

   // cmd_ready is only ever high in IDLE, so a command fire implies IDLE.
   assign w_cmd_fire = cmd_valid & r_cmd_ready;
   assign w_rsp_fire = r_rsp_valid & rsp_ready;
   assign w_idx_next = r_idx + 5'd1;

`ifdef REGFILE_DBG_VERIFY_EN
   logic r_err;
   assign err = r_err;
`else
   logic w_unused_rdat2;
   assign w_unused_rdat2 = ^rfif.rdat2;
   assign err            = 1'b0;
`endif

   // NOTE: every flop here sits on the async reset and uses non-blocking
   // assignment, so wen and the response drop the instant nRST falls.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= ST_IDLE;
         r_op        <= DBG_READ;
         r_idx       <= '0;
         r_wdat      <= '0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_sel   <= '0;
         r_rsp_dat   <= '0;
         r_wen       <= 1'b0;
         r_wsel      <= '0;
         r_rsel1     <= '0;
         r_rsel2     <= '0;
         r_rf_wdat   <= '0;
`ifdef REGFILE_DBG_VERIFY_EN
         r_err       <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  r_op        <= dbg_op_t'(cmd_op);
                  r_wdat      <= cmd_wdat;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  unique case (dbg_op_t'(cmd_op))
                     DBG_READ: begin
                        r_idx   <= cmd_sel;
                        r_rsel1 <= cmd_sel;
                        r_state <= ST_EXEC;
                     end
                     DBG_WRITE: begin
                        r_idx     <= cmd_sel;
                        r_rsel1   <= cmd_sel;
                        r_wen     <= 1'b1;
                        r_wsel    <= cmd_sel;
                        r_rf_wdat <= cmd_wdat;
                        r_state   <= ST_EXEC;
                     end
                     DBG_DUMP: begin
                        r_idx   <= '0;
                        r_rsel1 <= '0;
                        r_state <= ST_EXEC;
                     end
                     DBG_CLEAR: begin
                        r_idx     <= 5'd1;
                        r_wen     <= 1'b1;
                        r_wsel    <= 5'd1;
                        r_rf_wdat <= CLEAR_VALUE;
                        r_state   <= ST_CLR;
                     end
                  endcase
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_EXEC: begin
               r_wen       <= 1'b0;
               r_wsel      <= '0;
               r_rf_wdat   <= '0;
               r_rsp_sel   <= r_idx;
               r_rsp_dat   <= (r_op == DBG_WRITE) ? r_wdat : rfif.rdat1;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
`ifdef REGFILE_DBG_VERIFY_EN
               if (r_op == DBG_WRITE) begin
                  r_rsp_valid <= 1'b0;
                  r_rsel2     <= r_idx;
                  r_state     <= ST_VERIFY;
               end
`endif
            end
`ifdef REGFILE_DBG_VERIFY_EN
            // The write landed on the edge leaving EXEC, so rdat2 now shows it.
            ST_VERIFY: begin
               r_rsel2     <= '0;
               r_rsp_dat   <= rfif.rdat2;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
               if (r_idx != '0 && rfif.rdat2 != r_wdat) r_err <= 1'b1;
            end
`endif
            ST_CLR: begin
               if (r_idx == LAST_IDX) begin
                  r_wen       <= 1'b0;
                  r_wsel      <= '0;
                  r_rf_wdat   <= '0;
                  r_rsp_sel   <= '0;
                  r_rsp_dat   <= CLR_COUNT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_idx  <= w_idx_next;
                  r_wsel <= w_idx_next;
               end
            end
            ST_RESP: begin
               if (w_rsp_fire) begin
                  r_rsp_valid <= 1'b0;
                  if (r_op == DBG_DUMP && r_idx != LAST_IDX) begin
                     r_idx   <= w_idx_next;
                     r_rsel1 <= w_idx_next;
                     r_state <= ST_EXEC;
                  end else begin
                     r_busy      <= 1'b0;
                     r_cmd_ready <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_sel    = r_rsp_sel;
   assign rsp_dat    = r_rsp_dat;
   assign busy       = r_busy;
   assign rfif.wen   = r_wen;
   assign rfif.wsel  = r_wsel;
   assign rfif.rsel1 = r_rsel1;
   assign rfif.rsel2 = r_rsel2;
   assign rfif.wdat  = r_rf_wdat;

endmodule

// File: tb/tb_regfile_debug_master.sv
// Self-checking bench for regfile_debug_master: directed and random host commands checked against
// an array model of the register file; honours REGFILE_DBG_VERIFY_EN if defined.
module tb_regfile_debug_master;
   import cpu_types_pkg::*;

   localparam int    N       = 32;
   localparam word_t CLR_VAL = 32'h5A5A_0F0F;
   localparam int    TMO     = 100;

   logic     CLK       = 1'b0;
   logic     nRST      = 1'b0;
   logic     cmd_valid = 1'b0;
   logic     cmd_ready;
   logic [1:0] cmd_op  = 2'b00;
   regbits_t cmd_sel   = '0;
   word_t    cmd_wdat  = '0;
   logic     rsp_valid;
   logic     rsp_ready = 1'b0;
   regbits_t rsp_sel;
   word_t    rsp_dat;
   logic     busy;
   logic     err;

   int n_cmp = 0;
   int n_mis = 0;

   word_t mdl    [N];
   word_t rf_mem [32] = '{default: '0};

   register_file_if rfif();

   regfile_debug_master #(.NUM_REGS(N), .CLEAR_VALUE(CLR_VAL)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_sel  (cmd_sel),
      .cmd_wdat (cmd_wdat),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_sel  (rsp_sel),
      .rsp_dat  (rsp_dat),
      .busy     (busy),
      .err      (err),
      .rfif     (rfif)
   );

   always #5 CLK = ~CLK;

   // Register file: register 0 reads as zero, reads are combinational.
   always @(posedge CLK) if (rfif.wen && rfif.wsel != '0) rf_mem[rfif.wsel] <= rfif.wdat;
   assign rfif.rdat1 = (rfif.rsel1 == '0) ? '0 : rf_mem[rfif.rsel1];
   assign rfif.rdat2 = (rfif.rsel2 == '0) ? '0 : rf_mem[rfif.rsel2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // hold < 0 picks a random rsp_ready delay; abort_after >= 0 stops after that many responses.
   task automatic run_cmd(input dbg_op_t op, input regbits_t sel, input word_t wd,
                          input int hold, input int abort_after);
      regbits_t q_sel[$];
      word_t    q_dat[$];
      int       lat, exp_wen, edges, waited, nrsp, first_seen, held, h;
      int       wen_cnt, bad_w, bad_ctl;
      logic     acking;
      regbits_t cap_sel;
      word_t    cap_dat;

      lat = 2;
      exp_wen = 0;
      case (op)
         DBG_READ: begin
            q_sel.push_back(sel);
            q_dat.push_back(mdl[sel]);
         end
         DBG_WRITE: begin
            exp_wen = 1;
            if (sel != '0) mdl[sel] = wd;
            q_sel.push_back(sel);
`ifdef REGFILE_DBG_VERIFY_EN
            q_dat.push_back(mdl[sel]);
            lat = 3;
`else
            q_dat.push_back(wd);
`endif
         end
         DBG_DUMP: begin
            for (int k = 0; k < N; k++) begin
               q_sel.push_back(regbits_t'(k));
               q_dat.push_back(mdl[k]);
            end
         end
         DBG_CLEAR: begin
            exp_wen = N - 1;
            for (int k = 1; k < N; k++) mdl[k] = CLR_VAL;
            q_sel.push_back('0);
            q_dat.push_back(word_t'(N - 1));
            lat = N;
         end
      endcase

      @(negedge CLK);
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_wdat  = wd;
      @(negedge CLK);
      cmd_valid = 1'b0;
      edges = 1; waited = 0; nrsp = 0; first_seen = 0; held = 0; h = 0;
      wen_cnt = 0; bad_w = 0; bad_ctl = 0; acking = 1'b0;
      cap_sel = '0; cap_dat = '0;

      while (1) begin
         if (acking) begin
            acking = 1'b0;
            rsp_ready = 1'b0;
            nrsp++;
            held = 0;
            waited = 0;
            if (nrsp == q_sel.size() || nrsp == abort_after) break;
         end
         if (rfif.wen) begin
            if (op == DBG_CLEAR) begin
               if (rfif.wsel != regbits_t'(wen_cnt + 1) || rfif.wdat != CLR_VAL) bad_w++;
            end else if (op == DBG_WRITE) begin
               if (rfif.wsel != sel || rfif.wdat != wd) bad_w++;
            end else begin
               bad_w++;
            end
            wen_cnt++;
         end
         if (cmd_ready || !busy) bad_ctl++;
`ifndef REGFILE_DBG_VERIFY_EN
         if (rfif.rsel2 != '0) bad_ctl++;
`endif
         if (rsp_valid) begin
            if (held == 0) begin
               if (nrsp == 0) first_seen = edges;
               check($sformatf("rsp_sel[%0d]", nrsp), {27'd0, rsp_sel}, {27'd0, q_sel[nrsp]});
               check($sformatf("rsp_dat[%0d]", nrsp), rsp_dat, q_dat[nrsp]);
               cap_sel = rsp_sel;
               cap_dat = rsp_dat;
               h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
            end else if (rsp_sel != cap_sel || rsp_dat != cap_dat) begin
               bad_ctl++;
            end
            if (held >= h) begin
               rsp_ready = 1'b1;
               cmd_valid = 1'b0;
               acking    = 1'b1;
            end else begin
               // Offer a stray WRITE while busy; it must never be accepted.
               cmd_valid = 1'b1;
               cmd_op    = DBG_WRITE;
               cmd_sel   = regbits_t'($urandom_range(1, N - 1));
               cmd_wdat  = $urandom;
            end
            held++;
         end
         @(negedge CLK);
         edges++;
         waited++;
         if (waited > TMO) begin
            check("rsp_timeout", 32'd1, 32'd0);
            break;
         end
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check("first_rsp_latency", first_seen, lat);
      check("wen_cycles", wen_cnt, exp_wen);
      check("wen_bad_pulses", bad_w, 0);
      check("busy_phase_violations", bad_ctl, 0);
      check("err_clear", {31'd0, err}, 32'd0);
   endtask

   initial begin
      int r;
      for (int k = 0; k < N; k++) mdl[k] = '0;

      repeat (3) @(negedge CLK);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_wen", {31'd0, rfif.wen}, 32'd0);
      nRST = 1'b1;

      run_cmd(DBG_WRITE, 5'd5, 32'hDEAD_BEEF, -1, -1);
      run_cmd(DBG_READ, 5'd5, '0, -1, -1);
      run_cmd(DBG_WRITE, 5'd0, 32'h0000_1234, -1, -1);
      run_cmd(DBG_READ, 5'd0, '0, -1, -1);
      for (int k = 1; k < N; k++) run_cmd(DBG_WRITE, regbits_t'(k), word_t'(k), 0, -1);
      run_cmd(DBG_DUMP, '0, '0, -1, -1);
      run_cmd(DBG_CLEAR, '0, '0, -1, -1);
      run_cmd(DBG_DUMP, '0, '0, -1, -1);
      run_cmd(DBG_READ, 5'd7, '0, 5, -1);

      repeat (40) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)      run_cmd(DBG_READ,  regbits_t'($urandom_range(0, N - 1)), '0, -1, -1);
         else if (r < 8) run_cmd(DBG_WRITE, regbits_t'($urandom_range(0, N - 1)), $urandom, -1, -1);
         else if (r < 9) run_cmd(DBG_DUMP,  '0, '0, -1, -1);
         else            run_cmd(DBG_CLEAR, '0, '0, -1, -1);
      end

      // Reset while DUMP is about to read register 10.
      run_cmd(DBG_DUMP, '0, '0, 0, 10);
      #2 nRST = 1'b0;
      #1;
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_rsp_sel", {27'd0, rsp_sel}, 32'd0);
      check("midrst_rsp_dat", rsp_dat, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_wen", {31'd0, rfif.wen}, 32'd0);
      check("midrst_wsel", {27'd0, rfif.wsel}, 32'd0);
      check("midrst_rsel1", {27'd0, rfif.rsel1}, 32'd0);
      check("midrst_rsel2", {27'd0, rfif.rsel2}, 32'd0);
      check("midrst_wdat", rfif.wdat, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      run_cmd(DBG_DUMP, '0, '0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
